tt_um_ripple_div_ctrl: RTL and testbench

Synchronous controller for the 8-bit binary divider chain used as a free-running counter in the TinyTapeout designs. It replaces raw clock-driven rippling with a sequenced, fully synchronous 8-bit count. A small state machine handles start and stop, free-run versus one-shot mode, synchronous clear, and a selectable divide tap that emits a one-cycle tick. It is a standalone tile top; all control comes from the dedicated inputs.

---
 rtl/tt_um_ripple_div_ctrl.sv | 94 +++++++++
 tb/tb_tt_um_ripple_div_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_ripple_div_ctrl.sv
// Synchronous 8-bit divider-chain controller: start/stop sequencing, free-run or
// one-shot counting, synchronous clear and a selectable divide tap producing a tick.
module tt_um_ripple_div_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_ONESHOT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] count_q, count_d;
    logic       tick_q, tick_d;
    logic       mode_q, mode_d;
    logic       start_q, stop_q;
    logic       start_ev, stop_ev, clear, inc, mode_in;
    logic [2:0] sel;
    logic [7:0] tap_mask;
    logic       unused;

    assign mode_in  = ui_in[2];
    assign sel      = ui_in[5:3];
    assign clear    = ui_in[6];
    assign start_ev = ui_in[0] & ~start_q;
    assign stop_ev  = ui_in[1] & ~stop_q;
    assign tap_mask = 8'((9'd2 << sel) - 9'd1);
    assign unused   = &{1'b0, ui_in[7], uio_in};

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        count_d = count_q;
        tick_d  = 1'b0;
        inc     = 1'b0;
        if (stop_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ev) begin
                        mode_d  = mode_in;
                        state_d = mode_in ? S_ONESHOT : S_RUN;
                    end
                end
                S_RUN:     inc = 1'b1;
                S_ONESHOT: inc = 1'b1;
                default:   state_d = S_IDLE;
            endcase
        end
        // Clear suppresses the increment, so it also suppresses the tick and the DONE wrap.
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
            tick_d  = &(count_q | ~tap_mask);
            if (state_q == S_ONESHOT && count_q == 8'hFF) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tick_q  <= 1'b0;
            mode_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            mode_q  <= mode_d;
            start_q <= ui_in[0];
            stop_q  <= ui_in[1];
        end else begin
            // Drop any pending tick so it cannot reappear after re-enable.
            tick_q  <= 1'b0;
        end
    end

    assign uo_out  = count_q;
    assign uio_out = {5'b0, state_q == S_DONE,
                      (state_q == S_RUN) || (state_q == S_ONESHOT), tick_q & ena};
    assign uio_oe  = 8'b0000_0111;

endmodule

// File: tb/tb_tt_um_ripple_div_ctrl.sv
// Directed self-checking bench for tt_um_ripple_div_ctrl; expected values are
// hand-derived from edge counts relative to each start/stop event.
module tb_tt_um_ripple_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0, stop = 1'b0, mode = 1'b0, clr = 1'b0;
    logic [2:0] sel = 3'd0;
    logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
    logic       tick, busy, done;
    int unsigned n_pass = 0, n_total = 0;

    assign ui_in  = {1'b0, clr, sel, mode, stop, start};
    assign uio_in = 8'h00;
    assign tick   = uio_out[0];
    assign busy   = uio_out[1];
    assign done   = uio_out[2];

    always #5 clk = ~clk;

    tt_um_ripple_div_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_total++;
            if ({uo_out, uio_out, uio_oe} !== 24'h000007)
                $display("FAIL reset_idle cyc %0d got %h expected 000007", i, {uo_out, uio_out, uio_oe});
            else n_pass++;
        end
    endtask

    task automatic test_freerun_sel0();
        logic [7:0] exp_cnt;
        sel = 3'd0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({busy, done, uo_out} !== {2'b10, 8'h00})
            $display("FAIL freerun_start got busy=%b done=%b cnt=%h expected busy=1 done=0 cnt=00", busy, done, uo_out);
        else n_pass++;
        for (int k = 1; k <= 256; k++) begin
            step();
            exp_cnt = 8'(k);
            n_total++;
            if ({busy, tick, uo_out} !== {1'b1, (k % 2) == 0, exp_cnt})
                $display("FAIL freerun k=%0d got busy=%b tick=%b cnt=%h expected busy=1 tick=%b cnt=%h",
                         k, busy, tick, uo_out, (k % 2) == 0, exp_cnt);
            else n_pass++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_total++;
        if ({busy, uo_out} !== {1'b0, 8'h00})
            $display("FAIL freerun_stop got busy=%b cnt=%h expected busy=0 cnt=00", busy, uo_out);
        else n_pass++;
        step();
    endtask

    task automatic test_tap_sel3();
        logic [7:0] exp_cnt;
        sel = 3'd3; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step();
            exp_cnt = 8'(k);
            n_total++;
            if ({tick, uo_out} !== {(k % 16) == 0, exp_cnt})
                $display("FAIL tap_sel3 k=%0d got tick=%b cnt=%h expected tick=%b cnt=%h",
                         k, tick, uo_out, (k % 16) == 0, exp_cnt);
            else n_pass++;
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        logic [9:0] exp;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL idle_clear got cnt=%h expected 00", uo_out);
        else n_pass++;
        mode = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            step();
            exp = (k < 256) ? {2'b10, 8'(k)} : {2'b01, 8'h00};
            n_total++;
            if ({busy, done, uo_out} !== exp)
                $display("FAIL oneshot k=%0d got busy/done/cnt=%h expected %h", k, {busy, done, uo_out}, exp);
            else n_pass++;
        end
        for (int k = 0; k < 20; k++) begin
            step();
            n_total++;
            if ({busy, done, tick, uo_out} !== {3'b010, 8'h00})
                $display("FAIL oneshot_hold k=%0d got busy=%b done=%b tick=%b cnt=%h expected 0 1 0 00",
                         k, busy, done, tick, uo_out);
            else n_pass++;
        end
        mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n_total++;
        if ({busy, done, uo_out} !== {2'b10, 8'h00})
            $display("FAIL restart_run got busy=%b done=%b cnt=%h expected 1 0 00", busy, done, uo_out);
        else n_pass++;
    endtask

    task automatic test_stop_priority();
        for (int k = 0; k < 42; k++) step();
        n_total++;
        if (uo_out !== 8'h2A) $display("FAIL run_to_2a got cnt=%h expected 2a", uo_out);
        else n_pass++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_total++;
        if ({busy, done, uo_out} !== {2'b00, 8'h2A})
            $display("FAIL stop got busy=%b done=%b cnt=%h expected 0 0 2a", busy, done, uo_out);
        else n_pass++;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        n_total++;
        if ({busy, done, uo_out} !== {2'b00, 8'h2A})
            $display("FAIL start_stop_same got busy=%b done=%b cnt=%h expected 0 0 2a", busy, done, uo_out);
        else n_pass++;
        start = 1'b0; stop = 1'b0;
        step();
        n_total++;
        if ({busy, uo_out} !== {1'b0, 8'h2A})
            $display("FAIL start_stop_after got busy=%b cnt=%h expected 0 2a", busy, uo_out);
        else n_pass++;
    endtask

    task automatic test_clear_ena();
        sel = 3'd0; mode = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        n_total++;
        if ({busy, uo_out} !== {1'b1, 8'h2D})
            $display("FAIL resume_run got busy=%b cnt=%h expected 1 2d", busy, uo_out);
        else n_pass++;
        clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_total++;
            if ({busy, tick, uo_out} !== {2'b10, 8'h00})
                $display("FAIL clear k=%0d got busy=%b tick=%b cnt=%h expected 1 0 00", k, busy, tick, uo_out);
            else n_pass++;
        end
        clr = 1'b0;
        step();
        n_total++;
        if ({tick, uo_out} !== {1'b0, 8'h01})
            $display("FAIL after_clear1 got tick=%b cnt=%h expected 0 01", tick, uo_out);
        else n_pass++;
        step();
        n_total++;
        if ({busy, tick, uo_out} !== {2'b11, 8'h02})
            $display("FAIL after_clear2 got busy=%b tick=%b cnt=%h expected 1 1 02", busy, tick, uo_out);
        else n_pass++;
        ena = 1'b0;
        #1;
        n_total++;
        if (tick !== 1'b0) $display("FAIL ena_tick_gate got tick=%b expected 0", tick);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            step();
            n_total++;
            if ({busy, tick, uo_out} !== {2'b10, 8'h02})
                $display("FAIL ena_off k=%0d got busy=%b tick=%b cnt=%h expected 1 0 02", k, busy, tick, uo_out);
            else n_pass++;
        end
        ena = 1'b1;
        step();
        n_total++;
        if ({tick, uo_out} !== {1'b0, 8'h03})
            $display("FAIL ena_on1 got tick=%b cnt=%h expected 0 03", tick, uo_out);
        else n_pass++;
        step();
        n_total++;
        if ({tick, uo_out} !== {1'b1, 8'h04})
            $display("FAIL ena_on2 got tick=%b cnt=%h expected 1 04", tick, uo_out);
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        clr = 1'b1; start = 1'b1; rst_n = 1'b0;
        step();
        n_total++;
        if ({uo_out, uio_out} !== 16'h0000)
            $display("FAIL reset_midrun got out=%h expected 0000", {uo_out, uio_out});
        else n_pass++;
        rst_n = 1'b1; clr = 1'b0; start = 1'b0;
        step();
        n_total++;
        if ({uo_out, uio_out, uio_oe} !== 24'h000007)
            $display("FAIL reset_midrun_after got %h expected 000007", {uo_out, uio_out, uio_oe});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_freerun_sel0();
        test_tap_sel3();
        test_oneshot();
        test_stop_priority();
        test_clear_ena();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
